// File: rtl/fifo_mc_v4.sv
// fifo_mc_v4: NUM_CH independent FIFO queues sharing one push port and one pop port.
// Define FIFO_MC_ERR_EN to build the sticky overflow/underflow flags.
module fifo_mc_v4 #(
   parameter int FALL_THROUGH = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 8,
   parameter int NUM_CH       = 4,
   parameter int AF_TH        = DEPTH - 1,
   parameter int AE_TH        = 1,
   localparam int AW          = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW          = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
   localparam int CNTW        = AW + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic [NUM_CH-1:0]      flush_ch_i,
   input  logic                   push_i,
   input  logic [CW-1:0]          push_ch_i,
   input  logic [DATA_WIDTH-1:0]  data_i,
   input  logic                   pop_i,
   input  logic [CW-1:0]          pop_ch_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic [NUM_CH-1:0]      full_o,
   output logic [NUM_CH-1:0]      empty_o,
   output logic [NUM_CH-1:0]      almost_full_o,
   output logic [NUM_CH-1:0]      almost_empty_o,
   output logic [NUM_CH*CNTW-1:0] usage_o,
   output logic                   overflow_o,
   output logic                   underflow_o,
   input  logic                   err_clr_i
);
   logic [DATA_WIDTH-1:0] r_mem [NUM_CH][DEPTH];
   logic [AW-1:0]         r_rd  [NUM_CH];
   logic [AW-1:0]         r_wr  [NUM_CH];
   logic [CNTW-1:0]       r_cnt [NUM_CH];
   logic [NUM_CH-1:0]     w_flush, w_push_hit, w_pop_hit, w_push_ok, w_pop_ok, w_bypass, w_zero;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
   endfunction

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign w_flush[k]                = flush_i | flush_ch_i[k];
      assign w_push_hit[k]             = push_i & (push_ch_i == CW'(k));
      assign w_pop_hit[k]              = pop_i & (pop_ch_i == CW'(k));
      assign w_zero[k]                 = r_cnt[k] == '0;
      assign full_o[k]                 = r_cnt[k] == CNTW'(DEPTH);
      assign empty_o[k]                = w_zero[k] & ~((FALL_THROUGH != 0) & w_push_hit[k]);
      assign almost_full_o[k]          = r_cnt[k] >= CNTW'(AF_TH);
      assign almost_empty_o[k]         = r_cnt[k] <= CNTW'(AE_TH);
      assign usage_o[k*CNTW +: CNTW]   = r_cnt[k];
      assign w_push_ok[k]              = w_push_hit[k] & ~full_o[k] & ~w_flush[k];
      assign w_pop_ok[k]               = w_pop_hit[k] & ~empty_o[k] & ~w_flush[k];
      // Fall-through hand-off on an empty channel: data goes straight across, nothing stored
      assign w_bypass[k]               = w_push_ok[k] & w_pop_ok[k] & w_zero[k];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_rd[k]  <= '0;
            r_wr[k]  <= '0;
            r_cnt[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_flush[k]) begin
               r_rd[k]  <= '0;
               r_wr[k]  <= '0;
               r_cnt[k] <= '0;
            end else if (!w_bypass[k]) begin
               if (w_push_ok[k]) r_wr[k] <= nxt(r_wr[k]);
               if (w_pop_ok[k]) r_rd[k] <= nxt(r_rd[k]);
               r_cnt[k] <= r_cnt[k] + CNTW'(w_push_ok[k]) - CNTW'(w_pop_ok[k]);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NUM_CH; k++)
         if (w_push_ok[k] & ~w_bypass[k]) r_mem[k][r_wr[k]] <= data_i;
   end

   always_comb begin
      data_o = '0;
      for (int k = 0; k < NUM_CH; k++)
         if (pop_ch_i == CW'(k))
            data_o = (FALL_THROUGH != 0 && w_zero[k]) ? data_i : r_mem[k][r_rd[k]];
   end

`ifdef FIFO_MC_ERR_EN
   logic r_ovf, r_udf, w_ovf, w_udf;
   // Requests dropped because their channel is being flushed are not errors
   assign w_ovf = push_i & (~|w_push_hit | |(w_push_hit & full_o & ~w_flush));
   assign w_udf = pop_i & (~|w_pop_hit | |(w_pop_hit & empty_o & ~w_flush));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= w_ovf | (r_ovf & ~err_clr_i);
         r_udf <= w_udf | (r_udf & ~err_clr_i);
      end
   end

   assign overflow_o  = r_ovf;
   assign underflow_o = r_udf;
`else
   logic w_unused;
   assign w_unused    = err_clr_i;
   assign overflow_o  = 1'b0;
   assign underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_mc_v4.sv
// tb_fifo_mc_v4: directed + random stimulus on two fifo_mc_v4 configurations against a queue model.
module tb_fifo_mc_v4;
`ifdef FIFO_MC_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   logic       clk = 1'b0, rst = 1'b1;
   logic       flush, push, pop, err_clr;
   logic [3:0] flush_ch;
   logic [1:0] push_ch, pop_ch;
   logic [7:0] din;

   logic [7:0]  d0, d1;
   logic [3:0]  f0, e0, af0, ae0;
   logic [2:0]  f1, e1, af1, ae1;
   logic [11:0] u0;
   logic [8:0]  u1;
   logic        ov0, un0, ov1, un1;

   logic [7:0]  od  [2];
   logic [3:0]  of  [2];
   logic [3:0]  oe  [2];
   logic [3:0]  oaf [2];
   logic [3:0]  oae [2];
   logic [11:0] ou  [2];
   logic        oov [2];
   logic        oun [2];

   logic [7:0] mq [8][$];
   bit         eovf [2];
   bit         eudf [2];
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   fifo_mc_v4 #(.FALL_THROUGH(0), .DATA_WIDTH(8), .DEPTH(4), .NUM_CH(4), .AF_TH(3), .AE_TH(1)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_ch_i(flush_ch), .push_i(push), .push_ch_i(push_ch),
      .data_i(din), .pop_i(pop), .pop_ch_i(pop_ch), .data_o(d0), .full_o(f0), .empty_o(e0),
      .almost_full_o(af0), .almost_empty_o(ae0), .usage_o(u0), .overflow_o(ov0), .underflow_o(un0),
      .err_clr_i(err_clr));

   fifo_mc_v4 #(.FALL_THROUGH(1), .DATA_WIDTH(8), .DEPTH(3), .NUM_CH(3), .AF_TH(2), .AE_TH(0)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_ch_i(flush_ch[2:0]), .push_i(push), .push_ch_i(push_ch),
      .data_i(din), .pop_i(pop), .pop_ch_i(pop_ch), .data_o(d1), .full_o(f1), .empty_o(e1),
      .almost_full_o(af1), .almost_empty_o(ae1), .usage_o(u1), .overflow_o(ov1), .underflow_o(un1),
      .err_clr_i(err_clr));

   assign od[0] = d0;  assign od[1] = d1;
   assign of[0] = f0;  assign of[1] = {1'b0, f1};
   assign oe[0] = e0;  assign oe[1] = {1'b0, e1};
   assign oaf[0] = af0; assign oaf[1] = {1'b0, af1};
   assign oae[0] = ae0; assign oae[1] = {1'b0, ae1};
   assign ou[0] = u0;  assign ou[1] = {3'b0, u1};
   assign oov[0] = ov0; assign oov[1] = ov1;
   assign oun[0] = un0; assign oun[1] = un1;

   function automatic int nc(input int i);  return i ? 3 : 4; endfunction
   function automatic int dp(input int i);  return i ? 3 : 4; endfunction
   function automatic int aft(input int i); return i ? 2 : 3; endfunction
   function automatic int aet(input int i); return i ? 0 : 1; endfunction

   function automatic bit m_empty(input int i, input int k);
      return mq[i*4+k].size() == 0 && !(i == 1 && push && int'(push_ch) == k);
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s inst%0d observed=%h expected=%h", tag, i, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0]  ef, ee, eaf, eae;
      logic [11:0] eu;
      int          sz;
      for (int i = 0; i < 2; i++) begin
         ef = '0; ee = '0; eaf = '0; eae = '0; eu = '0;
         for (int k = 0; k < nc(i); k++) begin
            sz = mq[i*4+k].size();
            ef[k]         = sz == dp(i);
            ee[k]         = m_empty(i, k);
            eaf[k]        = sz >= aft(i);
            eae[k]        = sz <= aet(i);
            eu[k*3 +: 3]  = 3'(sz);
         end
         chk("full", i, 32'(of[i]), 32'(ef));
         chk("empty", i, 32'(oe[i]), 32'(ee));
         chk("almost_full", i, 32'(oaf[i]), 32'(eaf));
         chk("almost_empty", i, 32'(oae[i]), 32'(eae));
         chk("usage", i, 32'(ou[i]), 32'(eu));
         chk("overflow", i, 32'(oov[i]), 32'(eovf[i]));
         chk("underflow", i, 32'(oun[i]), 32'(eudf[i]));
         if (int'(pop_ch) < nc(i) && !ee[pop_ch])
            chk("data", i, 32'(od[i]), 32'(mq[i*4+int'(pop_ch)].size() > 0 ? mq[i*4+int'(pop_ch)][0] : din));
      end
   endtask

   task automatic model_tick();
      bit pin, pon, pfull, pfl, qe, qfl, pok, qok;
      for (int i = 0; i < 2; i++) begin
         pin   = push && int'(push_ch) < nc(i);
         pon   = pop && int'(pop_ch) < nc(i);
         pfull = pin && mq[i*4+int'(push_ch)].size() == dp(i);
         pfl   = pin && (flush || flush_ch[push_ch]);
         qe    = pon && m_empty(i, int'(pop_ch));
         qfl   = pon && (flush || flush_ch[pop_ch]);
         pok   = pin && !pfull && !pfl;
         qok   = pon && !qe && !qfl;
         if (ERR_EN) begin
            eovf[i] = (push && (!pin || (pfull && !pfl))) || (eovf[i] && !err_clr);
            eudf[i] = (pop && (!pon || (qe && !qfl))) || (eudf[i] && !err_clr);
         end
         if (!(qok && mq[i*4+int'(pop_ch)].size() == 0)) begin
            if (qok) void'(mq[i*4+int'(pop_ch)].pop_front());
            if (pok) mq[i*4+int'(push_ch)].push_back(din);
         end
         for (int k = 0; k < nc(i); k++)
            if (flush || flush_ch[k]) mq[i*4+k].delete();
      end
   endtask

   task automatic drive(input bit fl, input logic [3:0] fc, input bit pu, input logic [1:0] pc,
                        input logic [7:0] d, input bit po, input logic [1:0] oc, input bit ec);
      @(negedge clk);
      flush = fl; flush_ch = fc; push = pu; push_ch = pc; din = d; pop = po; pop_ch = oc; err_clr = ec;
      #1;
   endtask

   task automatic tick();
      check_all();
      @(posedge clk);
      model_tick();
   endtask

   task automatic op(input bit fl, input logic [3:0] fc, input bit pu, input logic [1:0] pc,
                     input logic [7:0] d, input bit po, input logic [1:0] oc, input bit ec);
      drive(fl, fc, pu, pc, d, po, oc, ec);
      tick();
   endtask

   task automatic rand_op();
      op($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0 ? 4'($urandom) : 4'b0,
         $urandom_range(0, 9) < 6, 2'($urandom), 8'($urandom),
         $urandom_range(0, 9) < 5, 2'($urandom), $urandom_range(0, 7) == 0);
   endtask

   task automatic check_reset();
      for (int i = 0; i < 2; i++) begin
         chk("rst_full", i, 32'(of[i]), 32'd0);
         chk("rst_empty", i, 32'(oe[i]), i ? 32'h7 : 32'hf);
         chk("rst_almost_full", i, 32'(oaf[i]), 32'd0);
         chk("rst_almost_empty", i, 32'(oae[i]), i ? 32'h7 : 32'hf);
         chk("rst_usage", i, 32'(ou[i]), 32'd0);
         chk("rst_overflow", i, 32'(oov[i]), 32'd0);
         chk("rst_underflow", i, 32'(oun[i]), 32'd0);
      end
   endtask

   initial begin
      flush = 0; flush_ch = '0; push = 0; push_ch = '0; din = '0; pop = 0; pop_ch = '0; err_clr = 0;
      #12;
      check_reset();
      @(negedge clk) rst = 1'b0;
      // ordered fill and drain of ch2
      for (int j = 0; j < 4; j++) op(0, 4'b0, 1, 2'd2, 8'(8'hA0 + j), 0, 2'd0, 0);
      drive(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd2, 0);
      chk("t1_full", 0, 32'(of[0]), 32'h4);
      chk("t1_usage", 0, 32'(ou[0][8:6]), 32'd4);
      tick();
      for (int j = 0; j < 4; j++) begin
         drive(0, 4'b0, 0, 2'd0, 8'h00, 1, 2'd2, 0);
         chk("t1_data", 0, 32'(od[0]), 32'(8'hA0 + j));
         tick();
      end
      drive(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 0);
      chk("t1_empty", 0, 32'(oe[0]), 32'hf);
      tick();
      // wrap on the DEPTH=3 instance
      for (int j = 0; j < 3; j++) op(0, 4'b0, 1, 2'd0, 8'(j), 0, 2'd0, 0);
      for (int j = 0; j < 3; j++) op(0, 4'b0, 0, 2'd0, 8'h00, 1, 2'd0, 0);
      for (int j = 0; j < 3; j++) op(0, 4'b0, 1, 2'd0, 8'(8'h10 + j), 0, 2'd0, 0);
      for (int j = 0; j < 3; j++) begin
         drive(0, 4'b0, 0, 2'd0, 8'h00, 1, 2'd0, 0);
         chk("t2_data", 1, 32'(od[1]), 32'(8'h10 + j));
         tick();
      end
      // concurrent push/pop, same and different channels
      op(0, 4'b0, 1, 2'd1, 8'h21, 0, 2'd0, 0);
      op(0, 4'b0, 1, 2'd1, 8'h22, 0, 2'd0, 0);
      op(0, 4'b0, 1, 2'd3, 8'h31, 0, 2'd0, 0);
      op(0, 4'b0, 1, 2'd1, 8'h23, 1, 2'd1, 0);
      op(0, 4'b0, 1, 2'd0, 8'h01, 1, 2'd3, 0);
      drive(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 0);
      chk("t3_usage1", 0, 32'(ou[0][5:3]), 32'd2);
      chk("t3_usage0", 0, 32'(ou[0][2:0]), 32'd1);
      chk("t3_usage3", 0, 32'(ou[0][11:9]), 32'd0);
      chk("t3_empty3", 0, 32'(oe[0][3]), 32'd1);
      tick();
      // full channel with push+pop, then error clear and pops past empty
      op(0, 4'b0, 1, 2'd1, 8'h24, 0, 2'd0, 0);
      op(0, 4'b0, 1, 2'd1, 8'h25, 0, 2'd0, 0);
      op(0, 4'b0, 1, 2'd1, 8'h26, 1, 2'd1, 0);
      drive(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 0);
      chk("t4_usage1", 0, 32'(ou[0][5:3]), 32'd3);
      tick();
      op(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 1);
      op(0, 4'b0, 0, 2'd0, 8'h00, 1, 2'd0, 0);
      op(0, 4'b0, 0, 2'd0, 8'h00, 1, 2'd0, 0);
      op(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 1);
      // fall-through on empty ch2 of the second instance
      drive(0, 4'b0, 1, 2'd2, 8'h55, 1, 2'd2, 0);
      chk("t5_data", 1, 32'(od[1]), 32'h55);
      chk("t5_empty2", 1, 32'(oe[1][2]), 32'd0);
      tick();
      drive(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 0);
      chk("t5_usage2", 1, 32'(ou[1][8:6]), 32'd0);
      tick();
      // per-channel flush beats a push to the same channel
      op(1, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 1);
      for (int j = 0; j < 2; j++) op(0, 4'b0, 1, 2'd1, 8'(8'h61 + j), 0, 2'd0, 0);
      for (int j = 0; j < 3; j++) op(0, 4'b0, 1, 2'd2, 8'(8'h71 + j), 0, 2'd0, 0);
      op(0, 4'b0010, 1, 2'd1, 8'h69, 0, 2'd0, 0);
      drive(0, 4'b0, 0, 2'd0, 8'h00, 0, 2'd0, 0);
      chk("t6_usage1", 0, 32'(ou[0][5:3]), 32'd0);
      chk("t6_usage2", 0, 32'(ou[0][8:6]), 32'd3);
      chk("t6_overflow", 0, 32'(oov[0]), 32'd0);
      tick();
      for (int n = 0; n < 600; n++) rand_op();
      // asynchronous reset between clock edges
      drive(0, 4'b0, 1, 2'd1, 8'h99, 0, 2'd0, 0);
      rst = 1'b1; push = 0; pop = 0;
      #1;
      check_reset();
      for (int k = 0; k < 8; k++) mq[k].delete();
      eovf[0] = 0; eovf[1] = 0; eudf[0] = 0; eudf[1] = 0;
      @(negedge clk) rst = 1'b0;
      for (int n = 0; n < 200; n++) rand_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
